ladybird_fetch: RTL and testbench
=================================

# ladybird_fetch

Instruction fetch stage between the instruction memory port and the decode stage of the ladybird core. It holds the fetch PC, issues word-aligned read requests on the instruction bus, and buffers returned instruction words together with their PCs in a small FIFO. The FIFO feeds decode through a valid/ready handshake. A redirect input (branch, jump or trap) flushes the buffer and restarts fetch at a new PC.

## Interface
- `XLEN`, 32: address and data width (taken from `ladybird_config`).
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'h0: fetch PC after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `anrst`  in  1  reset; asynchronous, active-low.
- `bus_req`  out  1  read request to the instruction bus.
- `bus_addr`  out  XLEN  request address; always word-aligned.
- `bus_wstrb`  out  XLEN/8  write strobes; constant 0 (read-only).
- `bus_gnt`  in  1  request accepted; `bus_rdata` is valid in this same cycle.
- `bus_rdata`  in  XLEN  returned instruction word.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  XLEN  new fetch PC; bits [1:0] are ignored and forced to 0.
- `inst_valid`  out  1  FIFO head holds an instruction.
- `inst_ready`  in  1  decode accepts the head entry.
- `inst_data`  out  XLEN  instruction word at the FIFO head.
- `inst_pc`  out  XLEN  PC of the FIFO head.

## Operation
- State:
  - `fetch_pc` register.
  - FIFO of {pc, word}, with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - `count` register of log2(DEPTH)+1 bits.
- `bus_req` = (`count` < DEPTH) and anrst deasserted. It is combinational from registered state.
- `bus_addr` = `fetch_pc`.
- `count` only increases on a push, so once `bus_req` is high it stays high until `bus_gnt`. The only exception is a redirect, which changes `bus_addr` while `bus_req` is high. The bus samples the address only in the `bus_gnt` cycle.
- Push: `bus_req` & `bus_gnt` & ~`redirect_valid`. Write {`fetch_pc`, `bus_rdata`} at the write pointer, then `fetch_pc` += 4, wrapping modulo 2^XLEN.
- Pop: `inst_valid` & `inst_ready` & ~`redirect_valid`. Advance the read pointer.
- Push and pop in the same cycle: `count` is unchanged. Neither happens when full, because `bus_req` is low when full.
- `inst_valid` = (`count` != 0).
- `inst_data` and `inst_pc` come from the head entry. Their value is don't-care when `inst_valid` is 0.
- Redirect has priority over everything else:
  - Pointers and `count` clear to 0.
  - `fetch_pc` <= {`redirect_pc`[XLEN-1:2], 2'b00}.
  - A `bus_gnt` in the same cycle is dropped: no push, and `fetch_pc` does not advance.
  - A decode handshake in the same cycle counts as taken by decode. Decode itself discards it on redirect.
- Consecutive redirects: the last one wins.

## Timing
- Reset values: `fetch_pc`=RESET_PC, `count`=0, pointers=0. Consequently:
  - `inst_valid`=0.
  - `bus_req`=1 and `bus_addr`=RESET_PC as soon as reset is released.
  - `bus_req` is 0 while reset is asserted.
  - `bus_wstrb`=0 at all times.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Any in-flight grant is lost.
- Fetch latency: `bus_gnt` in cycle N gives `inst_valid`=1 with that word in cycle N+1. There is no bypass from bus to decode.
- Redirect in cycle N: `bus_addr`=new PC and `inst_valid`=0 in cycle N+1. The first new instruction is visible at N+2 at the earliest.
- Throughput: one instruction per cycle when `bus_gnt` and `inst_ready` are continuously high.
- Full: with `count`=DEPTH, a pop in cycle N makes `bus_req` high in cycle N+1.

## Test plan
- **Reset and streaming.** Release `anrst` with `bus_gnt`=1, `bus_rdata`=addr^32'hA5A5_0000, `inst_ready`=1.
  - Required: `inst_pc` sequence 0,4,8,… from cycle 1, with one instruction per cycle and the matching data.
- **Fill and backpressure.** Hold `inst_ready`=0 and grant every cycle.
  - Required: exactly DEPTH (4) pushes, then `bus_req`=0 with `bus_addr`=16.
  - Then raise `inst_ready` for one cycle: `bus_req` returns next cycle and the entries drain in order 0,4,8,12.
- **Stalled bus.** Hold `bus_gnt`=0 for 5 cycles.
  - Required: `bus_req`=1 and `bus_addr` stable; `inst_valid` stays 0 with the FIFO empty.
- **Redirect with simultaneous grant.** With 3 entries buffered, assert `redirect_valid` with `redirect_pc`=32'h100 in the same cycle as `bus_gnt`.
  - Required: next cycle `inst_valid`=0 and `bus_addr`=32'h100; the granted word never appears at the output.
- **Misaligned redirect.** Set `redirect_pc`=32'h203.
  - Required: `bus_addr`=32'h200, then 32'h204.
- **Asynchronous reset mid-fill.** Assert `anrst` low between clock edges with 2 entries buffered.
  - Required: `inst_valid`=0 and `bus_req`=0 immediately.
  - After release: refetch from RESET_PC.

Source files
------------

// File: rtl/ladybird_fetch.sv
// ladybird_fetch: instruction fetch stage.
//   Holds the fetch PC, issues word-aligned read requests on the instruction
//   bus and buffers returned words with their PCs in a DEPTH-entry FIFO that
//   feeds decode through a valid/ready handshake. A redirect flushes the FIFO
//   and restarts fetch at the new (word-aligned) PC.
// Ports:
//   clk, anrst                   clock, asynchronous active-low reset
//   bus_req/bus_addr/bus_wstrb   read request to the instruction bus
//   bus_gnt/bus_rdata            grant, with read data valid in the same cycle
//   redirect_valid/redirect_pc   flush and restart fetch
//   inst_valid/inst_ready        FIFO head handshake towards decode
//   inst_data/inst_pc            head instruction word and its PC

package ladybird_config;
  localparam int unsigned XLEN = 32;
endpackage

module ladybird_fetch #(
  parameter int unsigned     XLEN     = ladybird_config::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              anrst,
  output logic              bus_req,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_gnt,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst_data,
  output logic [XLEN-1:0]   inst_pc
);

  localparam int unsigned    AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_word [DEPTH];
  logic            push;
  logic            pop;
  logic            redirect_pc_unused;

  // Low address bits of a redirect target are discarded.
  assign redirect_pc_unused = ^redirect_pc[1:0];

  // Gated by anrst so no request is visible while reset is held.
  assign bus_req    = anrst && (count < FULL_COUNT);
  assign bus_addr   = fetch_pc;
  assign bus_wstrb  = '0;
  assign inst_valid = (count != '0);
  assign inst_data  = mem_word[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];

  // Redirect suppresses both the push and the pop of its cycle.
  assign push = bus_req && bus_gnt && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= fetch_pc;
      mem_word[wr_ptr] <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_ladybird_fetch.sv
// Bench for ladybird_fetch: directed stimulus, a reference model that queues
// expected {pc, word} entries on each predicted push, and a monitor that pops
// and compares whenever decode takes the head entry.
module tb_ladybird_fetch;

  localparam logic [31:0] K     = 32'hA5A5_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        anrst = 1'b0;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt = 1'b0;
  logic [31:0] bus_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] mpc = 32'h0;
  int          mcount = 0;

  ladybird_fetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .anrst(anrst),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rdata(bus_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word is its address xor a constant.
  assign bus_rdata = bus_addr ^ K;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of fetch_pc / occupancy, updated as the DUT will be.
  always @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      exp_q.delete();
      mpc    = 32'h0;
      mcount = 0;
    end else if (redirect_valid) begin
      exp_q.delete();
      mpc    = {redirect_pc[31:2], 2'b00};
      mcount = 0;
    end else begin
      automatic bit p_push = (mcount < DEPTH) && bus_gnt;
      automatic bit p_pop  = (mcount != 0) && inst_ready;
      if (p_push) begin
        exp_q.push_back('{pc: mpc, word: mpc ^ K});
        mpc = mpc + 32'd4;
      end
      mcount = mcount + int'(p_push) - int'(p_pop);
    end
  end

  // Monitor: checks request/valid state every cycle and scores handshakes.
  always @(negedge clk) begin
    chk("bus_req", {31'b0, bus_req}, {31'b0, anrst && (mcount < DEPTH)});
    chk("bus_addr", bus_addr, mpc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, mcount != 0});
    chk("bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
    if (anrst && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", inst_pc, 32'hFFFF_FFFF);
      end else begin
        automatic entry_t e = exp_q.pop_front();
        chk("pop_pc", inst_pc, e.pc);
        chk("pop_data", inst_data, e.word);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held
    tick();
    tick();
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);

    // Reset release and streaming
    anrst = 1'b1; bus_gnt = 1'b1; inst_ready = 1'b1;
    #1;
    chk("rel_bus_req", {31'b0, bus_req}, 32'h1);
    chk("rel_bus_addr", bus_addr, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_valid", {31'b0, inst_valid}, 32'h1);
      chk("stream_pc", inst_pc, 32'(4 * i));
      chk("stream_data", inst_data, 32'(4 * i) ^ K);
    end

    // Fill and backpressure
    redirect_valid = 1'b1; redirect_pc = 32'h0; bus_gnt = 1'b0; inst_ready = 1'b0;
    tick();
    redirect_valid = 1'b0; bus_gnt = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("full_bus_req", {31'b0, bus_req}, 32'h0);
    chk("full_bus_addr", bus_addr, 32'h10);
    chk("full_head_pc", inst_pc, 32'h0);
    bus_gnt = 1'b0; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("unfull_bus_req", {31'b0, bus_req}, 32'h1);
    chk("unfull_head_pc", inst_pc, 32'h4);
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("drained_valid", {31'b0, inst_valid}, 32'h0);

    // Stalled bus
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_bus_req", {31'b0, bus_req}, 32'h1);
      chk("stall_bus_addr", bus_addr, 32'h10);
      chk("stall_valid", {31'b0, inst_valid}, 32'h0);
    end

    // Redirect with simultaneous grant, 3 entries buffered
    bus_gnt = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; bus_gnt = 1'b0;
    chk("redir_valid", {31'b0, inst_valid}, 32'h0);
    chk("redir_addr", bus_addr, 32'h100);
    bus_gnt = 1'b1; inst_ready = 1'b1;
    tick();
    chk("redir_first_pc", inst_pc, 32'h100);
    tick();
    chk("redir_second_pc", inst_pc, 32'h104);

    // Misaligned redirect
    bus_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    chk("misalign_addr0", bus_addr, 32'h200);
    bus_gnt = 1'b1;
    tick();
    chk("misalign_addr1", bus_addr, 32'h204);
    chk("misalign_pc", inst_pc, 32'h200);

    // Asynchronous reset mid-fill with 2 entries buffered
    bus_gnt = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0; bus_gnt = 1'b1;
    tick();
    tick();
    bus_gnt = 1'b0;
    chk("prerst_valid", {31'b0, inst_valid}, 32'h1);
    #2;
    anrst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, inst_valid}, 32'h0);
    chk("arst_bus_req", {31'b0, bus_req}, 32'h0);
    tick();
    anrst = 1'b1; bus_gnt = 1'b1; inst_ready = 1'b1;
    #1;
    chk("rerel_addr", bus_addr, 32'h0);
    tick();
    chk("rerel_pc", inst_pc, 32'h0);
    tick();
    chk("rerel_pc2", inst_pc, 32'h4);
    bus_gnt = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
